// File: rtl/sl_preceptron_gearbox_fifo.sv
// Lane-to-scalar gearbox FIFO: accepts up to DATA_LANES elements per beat and
// emits one element per cycle. Each entry carries a last flag for vector framing.
module sl_preceptron_gearbox_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_LANES = 4,
    parameter int DEPTH      = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH*DATA_LANES-1:0] in_data,
    input  logic [$clog2(DATA_LANES+1)-1:0]  in_cnt,
    input  logic                             in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_last,
    output logic [$clog2(DEPTH+1)-1:0]       level,
    output logic                             vec_done,
    output logic                             err
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int CW = $clog2(DATA_LANES+1);
    localparam logic [CW-1:0] LANES_C = CW'(DATA_LANES);

    logic [DATA_WIDTH:0] mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic                err_q, err_d, vec_done_q, vec_done_d;
    logic                wr_hs, rd_hs;
    logic [CW-1:0]       n;
    logic [DATA_WIDTH:0] head;

    // Oversized counts are clamped; the write still happens but is flagged.
    assign n        = (in_cnt > LANES_C) ? LANES_C : in_cnt;
    assign in_ready = rst_n && ((LW'(DEPTH) - level_q) >= LW'(DATA_LANES));
    assign out_valid = (level_q != '0);
    assign wr_hs    = in_valid && in_ready && !clr;
    assign rd_hs    = out_valid && out_ready && !clr;
    assign head     = mem_q[rd_ptr_q];
    assign out_data = out_valid ? head[DATA_WIDTH-1:0] : '0;
    assign out_last = out_valid && head[DATA_WIDTH];
    assign level    = level_q;
    assign vec_done = vec_done_q;
    assign err      = err_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        err_d      = err_q;
        level_d    = level_q + (wr_hs ? LW'(n) : '0) - LW'(rd_hs);
        vec_done_d = rd_hs && out_last;
        if (wr_hs) begin
            wr_ptr_d = wr_ptr_q + AW'(n);
            if (in_cnt == '0 || in_cnt > LANES_C) err_d = 1'b1;
        end
        if (rd_hs) rd_ptr_d = rd_ptr_q + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            err_q      <= 1'b0;
            vec_done_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            err_q      <= err_d;
            vec_done_q <= vec_done_d;
        end
    end

    // Storage is not reset; only lanes below the clamped count are written.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_LANES; i++) begin
            if (wr_hs && i < int'(n))
                mem_q[wr_ptr_q + AW'(i)] <= {in_last && (i == int'(n) - 1),
                                             in_data[i*DATA_WIDTH +: DATA_WIDTH]};
        end
    end
endmodule

// File: tb/tb_sl_preceptron_gearbox_fifo.sv
// Directed bench for the gearbox FIFO (DEPTH=64, 4 lanes of 8 bits) with a
// queue reference model checked after every clock edge.
module tb_sl_preceptron_gearbox_fifo;
    logic        clk = 1'b0;
    logic        rst_n, clr, in_valid, in_ready, in_last;
    logic [31:0] in_data;
    logic [2:0]  in_cnt;
    logic        out_valid, out_ready, out_last, vec_done, err;
    logic [7:0]  out_data;
    logic [6:0]  level;

    int passed = 0;
    int total  = 0;
    logic [8:0] q[$];
    logic       merr = 1'b0, mvd = 1'b0;
    int         val = 0;

    sl_preceptron_gearbox_fifo #(.DATA_WIDTH(8), .DATA_LANES(4), .DEPTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_cnt(in_cnt), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .level(level), .vec_done(vec_done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one clock, updating the model from the inputs presented this cycle.
    task automatic cyc();
        bit rd, wr;
        int n;
        logic [8:0] h;
        if (!rst_n || clr) begin
            q.delete();
            merr = 1'b0;
            mvd  = 1'b0;
        end else begin
            rd  = (q.size() != 0) && out_ready;
            wr  = in_valid && (64 - q.size() >= 4);
            mvd = 1'b0;
            if (rd) begin
                h   = q.pop_front();
                mvd = h[8];
            end
            if (wr) begin
                n = (in_cnt > 4) ? 4 : int'(in_cnt);
                if (in_cnt == 0 || in_cnt > 4) merr = 1'b1;
                for (int i = 0; i < n; i++)
                    q.push_back({in_last && (i == n - 1), in_data[i*8 +: 8]});
            end
        end
        @(posedge clk);
        #1;
        chk("level", 32'(level), 32'(q.size()));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("out_data", 32'(out_data), (q.size() != 0) ? 32'(q[0][7:0]) : 32'd0);
        chk("out_last", 32'(out_last), (q.size() != 0) ? 32'(q[0][8]) : 32'd0);
        chk("in_ready", 32'(in_ready), 32'(rst_n && (64 - q.size() >= 4)));
        chk("vec_done", 32'(vec_done), 32'(mvd));
        chk("err", 32'(err), 32'(merr));
    endtask

    task automatic beat(input int cnt, input logic last);
        in_valid = 1'b1;
        in_cnt   = 3'(cnt);
        in_last  = last;
        for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = 8'(val + i);
        val += (cnt > 4) ? 4 : cnt;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 200 && q.size() != 0; k++) cyc();
        chk("drain_empty", 32'(level), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0;
        in_cnt = '0; in_last = 1'b0; out_ready = 1'b0;
        cyc();
        cyc();
        chk("rst_in_ready_low", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready_high", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);

        // Basic order: one full beat, one element per cycle after.
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h04030201; in_cnt = 3'd4; in_last = 1'b1;
        cyc();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("basic_data", 32'(out_data), 32'(k + 1));
            chk("basic_last", 32'(out_last), 32'(k == 3));
            chk("basic_level", 32'(level), 32'(4 - k));
            cyc();
        end
        chk("basic_vec_done", 32'(vec_done), 32'd1);
        cyc();
        chk("basic_vec_done_clear", 32'(vec_done), 32'd0);

        // Fill to DEPTH with backpressure, then drain in order.
        out_ready = 1'b0;
        val = 0;
        for (int b = 0; b < 16; b++) beat(4, b == 15);
        chk("full_level", 32'(level), 32'd64);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        cyc();
        chk("full_level63_not_ready", 32'(in_ready), 32'd0);
        for (int k = 1; k < 64; k++) begin
            chk("full_order", 32'(out_data), 32'(k));
            cyc();
        end
        chk("full_drained", 32'(out_valid), 32'd0);

        // Simultaneous write and read at level = DEPTH - DATA_LANES.
        out_ready = 1'b0;
        for (int b = 0; b < 15; b++) beat(4, 1'b0);
        chk("sim_level60", 32'(level), 32'd60);
        chk("sim_ready60", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        beat(4, 1'b1);
        chk("sim_level63", 32'(level), 32'd63);
        chk("sim_ready_drop", 32'(in_ready), 32'd0);
        drain();

        // Partial beats with pointer wrap and a fixed out_ready pattern.
        for (int b = 0; b < 44; b++) begin
            out_ready = (b % 3) != 2;
            beat((b % 2 == 0) ? 3 : 1, b % 2 == 1);
        end
        drain();

        // Error beats and flush mid-vector.
        out_ready = 1'b0;
        beat(0, 1'b1);
        chk("err_cnt0", 32'(err), 32'd1);
        chk("err_cnt0_level", 32'(level), 32'd0);
        beat(1, 1'b1);
        beat(5, 1'b0);
        chk("err_cnt5_level", 32'(level), 32'd5);
        beat(1, 1'b0);
        chk("clr_pre_level", 32'(level), 32'd6);
        chk("clr_pre_head_last", 32'(out_last), 32'd1);
        clr = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_cnt = 3'd4;
        cyc();
        clr = 1'b0; in_valid = 1'b0;
        chk("clr_level", 32'(level), 32'd0);
        chk("clr_err", 32'(err), 32'd0);
        chk("clr_vec_done", 32'(vec_done), 32'd0);
        chk("clr_out_valid", 32'(out_valid), 32'd0);

        // Reset mid-operation at level 10, then a fresh vector.
        out_ready = 1'b0;
        beat(4, 1'b0);
        beat(4, 1'b0);
        beat(2, 1'b0);
        chk("rstmid_level", 32'(level), 32'd10);
        rst_n = 1'b0; in_valid = 1'b1; in_cnt = 3'd4;
        cyc();
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rstmid_level0", 32'(level), 32'd0);
        chk("rstmid_out_data", 32'(out_data), 32'd0);
        chk("rstmid_in_ready", 32'(in_ready), 32'd1);
        val = 8'hA0;
        out_ready = 1'b1;
        beat(3, 1'b1);
        chk("rstmid_first", 32'(out_data), 32'hA0);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
